uart_tx_scheduler: RTL and testbench

Shares one UART transmit line between `NUM_REQ` byte requesters. Each requester uses a valid/ready handshake, and grants rotate round-robin. The granted byte is serialized as an 8N1 frame (8E1 when parity is compiled in). Bit timing comes from the external `baud_tick` pulse produced by the TX baud-rate generator, so this block contains no divider of its own.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 46 ++++
 rtl/uart_tx_scheduler.sv | 154 +++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  // Line levels for the idle/stop condition and the start bit.
  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;

  // Default payload width of one frame.
  localparam int UART_DATA_W = 8;

  // Transmit FSM states. PARITY only exists when parity is compiled in.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd4,
`endif
    ST_STOP   = 3'd5
  } uart_tx_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester above ptr, wrapping to index 0.
// Latency: purely combinational, grant valid in the same cycle as req.
// Backpressure: en=0 forces an all-zero grant; pointer is owned by the caller.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  input  logic                       en,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic            found_hi;
  logic            found_lo;
  logic [ID_W-1:0] hi_idx;
  logic [ID_W-1:0] lo_idx;

  // Find the lowest request strictly above ptr, and the lowest request overall
  // as the wrap-around fallback; the former wins when it exists.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    gnt      = '0;
    gnt_id   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i] && (ID_W'(i) > ptr) && !found_hi) begin
        found_hi = 1'b1;
        hi_idx   = ID_W'(i);
      end
      if (req[i] && !found_lo) begin
        found_lo = 1'b1;
        lo_idx   = ID_W'(i);
      end
    end
    if (en && (found_hi || found_lo)) begin
      gnt_id      = found_hi ? hi_idx : lo_idx;
      gnt[gnt_id] = 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART TX line among NUM_REQ byte requesters (round-robin); optional even parity via UART_TX_PARITY_EN.
// Latency: req_ready same cycle in IDLE; start bit begins at first baud_tick after capture; frame = DATA_W+2 (+1 parity) bit periods.
// Backpressure: req_ready is low for the whole frame and while rst is high; requesters hold valid/data until accepted.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = UART_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       baud_tick,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  uart_tx_state_e     state;
  logic [ID_W-1:0]    ptr;
  logic [DATA_W-1:0]  shreg;
  logic [IDX_W-1:0]   bit_idx;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               arb_en;
  logic               capture;
  logic [DATA_W-1:0]  sel_data;
`ifdef UART_TX_PARITY_EN
  logic               par_q;
`endif

  // Grants are only offered while idle and never during reset.
  assign arb_en = (state == ST_IDLE) && !rst;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .en    (arb_en),
    .gnt   (gnt),
    .gnt_id(gnt_id)
  );

  assign req_ready = gnt;
  assign capture   = |(req_valid & gnt);

  // Select the granted requester's payload with a one-hot mux.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  // Even parity of the accepted byte, computed once at capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if ((state == ST_IDLE) && capture) begin
      par_q <= ^sel_data;
    end
  end
`endif

  // Transmit FSM: capture in IDLE, then one state per baud period. The data
  // bits leave LSB first from a right-shifting register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      tx       <= UART_IDLE_LVL;
      busy     <= 1'b0;
      grant_id <= '0;
      ptr      <= ID_W'(NUM_REQ - 1);
      shreg    <= '0;
      bit_idx  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          tx <= UART_IDLE_LVL;
          // A baud_tick on the capture edge is deliberately ignored so the
          // SYNC state always lasts up to the next full tick.
          if (capture) begin
            shreg    <= sel_data;
            grant_id <= gnt_id;
            ptr      <= gnt_id;
            busy     <= 1'b1;
            state    <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (baud_tick) begin
            state <= ST_START;
            tx    <= UART_START_LVL;
          end
        end
        ST_START: begin
          if (baud_tick) begin
            state   <= ST_DATA;
            bit_idx <= '0;
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
          end
        end
        ST_DATA: begin
          if (baud_tick) begin
            if (bit_idx == IDX_W'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
              state <= ST_PARITY;
              tx    <= par_q;
`else
              state <= ST_STOP;
              tx    <= UART_IDLE_LVL;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (baud_tick) begin
            state <= ST_STOP;
            tx    <= UART_IDLE_LVL;
          end
        end
`endif
        ST_STOP: begin
          if (baud_tick) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            tx    <= UART_IDLE_LVL;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          tx    <= UART_IDLE_LVL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: table of frames plus reset and handshake corner cases.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_scheduler;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk;
  logic        rst;
  logic        baud_tick;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx;
  logic        busy;
  logic [1:0]  grant_id;

  uart_tx_scheduler #(
    .NUM_REQ(4),
    .DATA_W (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .baud_tick(baud_tick),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .tx       (tx),
    .busy     (busy),
    .grant_id (grant_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        do_rst;
    int          period;
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  exp_ready;
    logic [1:0]  exp_gid;
  } row_t;

  row_t rows [11];

  int   total = 0;
  int   passed = 0;
  int   cyc = 0;
  int   tick_cnt = 0;
  int   tick_period = 16;
  logic last_tick = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // One clock: inputs change and outputs are sampled 1 time unit after posedge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    last_tick = baud_tick;
    if (tick_cnt >= tick_period - 1) begin
      tick_cnt  = 0;
      baud_tick = 1'b1;
    end else begin
      tick_cnt++;
      baud_tick = 1'b0;
    end
  endtask

  task automatic wait_tick(output logic ok);
    int wd;
    wd = 0;
    ok = 1'b0;
    while (!ok && wd < 3000) begin
      step();
      wd++;
      if (last_tick) ok = 1'b1;
    end
  endtask

  task automatic do_reset(input int period);
    req_valid   = '0;
    rst         = 1'b1;
    tick_period = period;
    tick_cnt    = 0;
    baud_tick   = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic logic [11:0] frame_of(input logic [7:0] b);
    logic [11:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef UART_TX_PARITY_EN
    f[9]   = ^b;
`endif
    return f;
  endfunction

  initial begin
    row_t        rw;
    logic [7:0]  eb;
    logic [11:0] got;
    logic [31:0] dw;
    logic        ok;
    logic        bad;
    logic        r0_seen;
    int          n;
    int          wd;
    int          start_cyc;
    int          end_cyc;
    int          cap_cyc;

    rst       = 1'b1;
    baud_tick = 1'b0;
    req_valid = '0;
    req_data  = '0;
    end_cyc   = 0;

    //          rst   per valid    data          ready    gid
    rows[0]  = '{1'b1, 16, 4'b0100, 32'h3CA55A0F, 4'b0100, 2'd2};
    rows[1]  = '{1'b1, 16, 4'b1111, 32'h44332211, 4'b0001, 2'd0};
    rows[2]  = '{1'b0, 16, 4'b1111, 32'h44332211, 4'b0010, 2'd1};
    rows[3]  = '{1'b0, 16, 4'b1111, 32'h44332211, 4'b0100, 2'd2};
    rows[4]  = '{1'b0, 16, 4'b1111, 32'h44332211, 4'b1000, 2'd3};
    rows[5]  = '{1'b0, 16, 4'b1111, 32'h804020FE, 4'b0001, 2'd0};
    rows[6]  = '{1'b0, 16, 4'b1010, 32'h9900C300, 4'b0010, 2'd1};
    rows[7]  = '{1'b0, 16, 4'b1001, 32'h070000EE, 4'b1000, 2'd3};
    rows[8]  = '{1'b0, 16, 4'b0001, 32'h00000003, 4'b0001, 2'd0};
    rows[9]  = '{1'b0, 16, 4'b0011, 32'h0000FF00, 4'b0010, 2'd1};
    rows[10] = '{1'b1,  3, 4'b0001, 32'h00000080, 4'b0001, 2'd0};

    // Reset state and a long idle stretch.
    do_reset(16);
    chk("reset tx", {31'd0, tx}, 32'd1);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset grant_id", {30'd0, grant_id}, 32'd0);
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (tx !== 1'b1 || busy !== 1'b0 || req_ready !== 4'b0000) bad = 1'b1;
    end
    chk("idle 100 clks", {31'd0, bad}, 32'd0);

    // Table of frames: grant order, payload serialization and timing.
    for (int r = 0; r < 11; r++) begin
      rw = rows[r];
      if (rw.do_rst) do_reset(rw.period);
      req_valid = rw.valid;
      req_data  = rw.data;
      dw        = rw.data;
      eb        = dw[rw.exp_gid*8 +: 8];
      #1;
      chk($sformatf("row%0d req_ready", r), {28'd0, req_ready}, {28'd0, rw.exp_ready});
      step();
      chk($sformatf("row%0d grant_id", r), {30'd0, grant_id}, {30'd0, rw.exp_gid});
      chk($sformatf("row%0d busy rise", r), {31'd0, busy}, 32'd1);
      chk($sformatf("row%0d ready low", r), {28'd0, req_ready}, 32'd0);
      got       = '1;
      n         = 0;
      wd        = 0;
      start_cyc = 0;
      while (n < NB && wd < 3000) begin
        step();
        wd++;
        if (last_tick) begin
          got[n] = tx;
          if (n == 0) start_cyc = cyc;
          n++;
        end
      end
      chk($sformatf("row%0d bits seen", r), n, NB);
      chk($sformatf("row%0d frame", r), {20'd0, got}, {20'd0, frame_of(eb)});
      if (!rw.do_rst) chk($sformatf("row%0d idle gap", r), start_cyc - end_cyc, rw.period);
      wait_tick(ok);
      chk($sformatf("row%0d busy fall", r), {31'd0, busy & ok}, 32'd0);
      chk($sformatf("row%0d frame length", r), cyc - start_cyc, NB * rw.period);
      end_cyc = cyc;
    end

    // Reset in the middle of data bit 4 abandons the frame.
    do_reset(16);
    req_valid = 4'b0100;
    req_data  = 32'h00EF0000;
    step();
    req_valid = '0;
    for (int t = 0; t < 6; t++) wait_tick(ok);
    chk("mid-frame tx bit4", {31'd0, tx}, 32'd0);
    req_valid = 4'b1010;
    req_data  = 32'h5500AA00;
    #3;
    rst = 1'b1;
    #1;
    chk("async rst tx", {31'd0, tx}, 32'd1);
    chk("async rst busy", {31'd0, busy}, 32'd0);
    chk("async rst ready", {28'd0, req_ready}, 32'd0);
    step();
    step();
    rst = 1'b0;
    #1;
    chk("post-rst ready", {28'd0, req_ready}, 32'b0010);
    step();
    chk("post-rst grant_id", {30'd0, grant_id}, 32'd1);
    req_valid = '0;
    wd = 0;
    while (busy && wd < 3000) begin
      step();
      wd++;
    end
    chk("post-rst frame ends", {31'd0, busy}, 32'd0);

    // Capture on a tick edge; requester 0 appears then withdraws while busy.
    wd = 0;
    while (!baud_tick && wd < 100) begin
      step();
      wd++;
    end
    req_valid = 4'b0010;
    req_data  = 32'h00003C00;
    #1;
    chk("coinc ready", {28'd0, req_ready}, 32'b0010);
    step();
    cap_cyc = cyc;
    chk("coinc grant_id", {30'd0, grant_id}, 32'd1);
    chk("coinc tx still idle", {31'd0, tx}, 32'd1);
    req_valid = 4'b0011;
    r0_seen   = 1'b0;
    ok        = 1'b0;
    wd        = 0;
    while (!ok && wd < 3000) begin
      step();
      wd++;
      r0_seen = r0_seen | req_ready[0];
      if (last_tick) ok = 1'b1;
    end
    chk("coinc sync length", cyc - cap_cyc, 16);
    chk("coinc start bit", {31'd0, tx}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      r0_seen = r0_seen | req_ready[0];
    end
    req_valid = '0;
    wd = 0;
    while (busy && wd < 3000) begin
      step();
      wd++;
      r0_seen = r0_seen | req_ready[0];
    end
    bad = busy;
    for (int i = 0; i < 40; i++) begin
      step();
      if (busy !== 1'b0 || req_ready !== 4'b0000) bad = 1'b1;
    end
    chk("dropped req0 never ready", {31'd0, r0_seen}, 32'd0);
    chk("dropped req0 no frame", {31'd0, bad}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
